// File: rtl/bubble_pkg.sv
// Shared definitions for the bubble output buffer: access-type codes,
// load-state encoding and default address constants.
package bubble_pkg;

  localparam logic [2:0] ACC_BOOT  = 3'b110;
  localparam logic [2:0] ACC_USER  = 3'b111;
  localparam logic [2:0] PAGE_BASE = 3'b111;
  localparam logic       FILL_BIT  = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } buf_state_e;

  // All-ones line address of a given width, used for the empty propagation line.
  function automatic logic [31:0] idle_line(input int aw);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < aw; i++) begin
      v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/bubble_bitram.sv
// 1-bit x 2**AW simple dual-port RAM, single clock, read-first on same-address access.
module bubble_bitram #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  logic mem_q [0:(2**AW)-1];
  logic rdata_q;

  // Both accesses use non-blocking updates, so a same-edge read sees the old bit.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bubble_outbuffer_ctrl.sv
// N-channel bit-wide page buffer between the page loader and the DOUTx drivers:
// write decode, read address mapping, load-state FSM, registered output and collision flag.
module bubble_outbuffer_ctrl
  import bubble_pkg::*;
#(
  parameter int            MAXCH    = 4,
  parameter int            AW       = 13,
  parameter logic [2:0]    BOOTTYPE = ACC_BOOT,
  parameter logic [2:0]    USERTYPE = ACC_USER,
  parameter logic [2:0]    PAGEBASE = PAGE_BASE,
  parameter logic [AW-1:0] IDLEADDR = AW'(idle_line(AW))
) (
  input  logic             MCLK,
  input  logic             RESET,
  input  logic             FOURBITMODE,
  input  logic [2:0]       ACCTYPE,
  input  logic [AW-1:0]    BOUTCYCLENUM,
  input  logic             BOUTTICK,
  input  logic [AW+1:0]    OUTBUFWADDR,
  input  logic             OUTBUFWE,
  input  logic             OUTBUFWDATA,
  input  logic             LOADDONE,
  output logic [MAXCH-1:0] DOUT,
  output logic             DOUTVALID,
  output logic             BUFREADY,
  output logic             COLLISION
);

  buf_state_e       state_q, state_d;
  logic             mode_q, mode_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_ready_q, rd_ready_d;
  logic             rd_mode4_q, rd_mode4_d;
  logic [MAXCH-1:0] dout_q, dout_d;
  logic             doutvalid_q, doutvalid_d;
  logic             bufready_q, bufready_d;
  logic             coll_q, coll_d;

  logic             wr_mode4_s;
  logic [1:0]       wr_ch_s;
  logic [AW-1:0]    wr_addr_s;
  logic             wr_ok_s;
  logic [AW-1:0]    rd_addr_s;
  logic [MAXCH-1:0] ram_we_s;
  logic [MAXCH-1:0] ram_rdata_s;

  // Write decode; the very first write of a load is decoded with the live mode pin.
  always_comb begin
    wr_mode4_s = (state_q == ST_EMPTY) ? FOURBITMODE : mode_q;
    if (wr_mode4_s) begin
      wr_ch_s   = OUTBUFWADDR[1:0];
      wr_addr_s = OUTBUFWADDR[AW+1:2];
    end else begin
      wr_ch_s   = {1'b0, OUTBUFWADDR[0]};
      wr_addr_s = OUTBUFWADDR[AW:1];
    end
    wr_ok_s = OUTBUFWE && !RESET && (int'(wr_ch_s) < MAXCH);
    for (int i = 0; i < MAXCH; i++) begin
      ram_we_s[i] = wr_ok_s && (int'(wr_ch_s) == i);
    end
  end

  // Read address mapping from access type.
  always_comb begin
    case (ACCTYPE)
      BOOTTYPE: rd_addr_s = BOUTCYCLENUM;
      USERTYPE: rd_addr_s = {PAGEBASE, BOUTCYCLENUM[AW-4:0]};
      default:  rd_addr_s = IDLEADDR;
    endcase
  end

  for (genvar g = 0; g < MAXCH; g++) begin : g_ch
    bubble_bitram #(.AW(AW)) u_ram (
      .clk   (MCLK),
      .we    (ram_we_s[g]),
      .waddr (wr_addr_s),
      .wdata (OUTBUFWDATA),
      .re    (BOUTTICK),
      .raddr (rd_addr_s),
      .rdata (ram_rdata_s[g])
    );
  end

  // Load-state FSM; a write together with LOADDONE lands straight in READY.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      ST_EMPTY: begin
        if (OUTBUFWE) begin
          mode_d  = FOURBITMODE;
          state_d = LOADDONE ? ST_READY : ST_LOADING;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_LOADING: begin
        if (LOADDONE) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_LOADING;
        end
      end
      ST_READY: begin
        if (OUTBUFWE && !LOADDONE) begin
          state_d = ST_LOADING;
        end else begin
          state_d = ST_READY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output stage: RAM data arrives one edge after the tick and is shaped here.
  always_comb begin
    rd_pend_d   = BOUTTICK;
    rd_ready_d  = (state_q == ST_READY);
    rd_mode4_d  = mode_q;
    doutvalid_d = rd_pend_q;
    bufready_d  = (state_d == ST_READY);
    coll_d      = coll_q || (BOUTTICK && wr_ok_s && (wr_addr_s == rd_addr_s));
    dout_d      = dout_q;
    if (rd_pend_q) begin
      if (!rd_ready_q) begin
        dout_d = {MAXCH{FILL_BIT}};
      end else begin
        for (int i = 0; i < MAXCH; i++) begin
          dout_d[i] = ((i < 2) || rd_mode4_q) ? ram_rdata_s[i] : 1'b0;
        end
      end
    end else begin
      dout_d = dout_q;
    end
  end

  // State and output registers.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_EMPTY;
      mode_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_ready_q  <= 1'b0;
      rd_mode4_q  <= 1'b0;
      dout_q      <= {MAXCH{1'b0}};
      doutvalid_q <= 1'b0;
      bufready_q  <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rd_pend_q   <= rd_pend_d;
      rd_ready_q  <= rd_ready_d;
      rd_mode4_q  <= rd_mode4_d;
      dout_q      <= dout_d;
      doutvalid_q <= doutvalid_d;
      bufready_q  <= bufready_d;
      coll_q      <= coll_d;
    end
  end

  assign DOUT      = dout_q;
  assign DOUTVALID = doutvalid_q;
  assign BUFREADY  = bufready_q;
  assign COLLISION = coll_q;

endmodule
